// File: rtl/piso_serializer.sv
//==============================================================================
// Module   : piso_serializer
// Brief    : Parallel-in/serial-out converter with a one-word holding buffer
//            so consecutive words stream out with no idle cycle between frames.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [WIDTH-1:0] r_hold;
    logic [WIDTH-1:0] w_hold_nxt;
    logic             r_hold_full;
    logic             w_hold_full_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;
    logic             w_xfer;
    logic             w_last;
    logic             w_shifting;

    // Shift direction moves bits toward the output end; vacated positions fill with 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_out_bit = r_shreg[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_out_bit = r_shreg[0];
        end
    endgenerate

    // Ready depends only on registered state and reset, so a producer may
    // safely derive load_valid from it.
    assign load_ready   = !r_hold_full && !reset;
    assign w_xfer       = load_valid && load_ready;
    assign w_shifting   = (r_state == SHIFT);
    assign w_last       = (r_cnt == LAST_BIT);

    assign serial_valid = w_shifting;
    assign serial_out   = w_shifting && w_out_bit;
    assign frame_start  = w_shifting && (r_cnt == '0);
    assign frame_end    = w_shifting && w_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_shreg_nxt = parallel_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    if (r_hold_full) begin
                        w_shreg_nxt     = r_hold;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_xfer) begin
                        // Bypass the empty hold so the next frame follows with no gap.
                        w_shreg_nxt = parallel_in;
                    end else begin
                        w_shreg_nxt = w_shifted;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_shreg_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt + CNT_ONE;
                    if (w_xfer) begin
                        w_hold_nxt      = parallel_in;
                        w_hold_full_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in/serial-out converter. It is the transmit end for the team's sipo deserializer.
- Accepts WIDTH-bit words over a valid/ready load handshake.
- Shifts each word out one bit per clock, with framing strobes.
- A one-word holding buffer lets back-to-back words stream with no idle cycle between frames.

Parameters:
WIDTH, 4, word width in bits; legal range 2 and up.
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
clock  input  1  single system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
parallel_in  input  WIDTH  word to serialize; sampled on an accepted load.
load_valid  input  1  producer has a word on parallel_in.
load_ready  output  1  block can accept a word this cycle.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out carries a frame bit this cycle.
frame_start  output  1  high on the first bit of each frame.
frame_end  output  1  high on the last bit of each frame.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values:
  - state IDLE; shift register 0; bit counter 0; holding buffer empty.
  - serial_out 0, serial_valid 0, frame_start 0, frame_end 0.
  - load_ready is 0 while reset is high and 1 in the first cycle after reset deasserts.
- Internal state: shift register (WIDTH), bit counter ($clog2(WIDTH) bits, 0..WIDTH-1), holding register (WIDTH), hold_full flag, 2-state FSM (IDLE, SHIFT).
- Handshake:
  - Transfer occurs on a rising edge where load_valid && load_ready.
  - load_ready = !hold_full && !reset, a combinational function of registered state only.
  - load_valid is allowed to depend on load_ready without creating a loop.
  - parallel_in is ignored when no transfer occurs.
- IDLE:
  - serial_valid=0, serial_out=0.
  - On a transfer: word loads into the shift register, counter=0, next state SHIFT.
  - The first bit appears on serial_out in the cycle immediately after the accepting edge (latency 1).
- SHIFT:
  - serial_valid=1.
  - serial_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - Each edge shifts one position toward the output end and increments the counter.
  - A transfer while in SHIFT writes the holding register and sets hold_full.
- Last bit (counter==WIDTH-1), on the edge, exactly one of:
  - (a) hold_full: holding register moves to the shift register, counter=0, hold_full cleared, stay SHIFT.
  - (b) hold empty and a transfer occurs this cycle: parallel_in bypasses directly into the shift register, counter=0, stay SHIFT.
  - (c) otherwise: go to IDLE, counter=0.
  - In cases (a) and (b) the next frame's first bit follows with zero gap.
- Strobes:
  - frame_start = serial_valid && counter==0.
  - frame_end = serial_valid && counter==WIDTH-1.
  - Both are combinational from registers and glitch-free at the edge.
- Occupancy: at most 2 words in flight (shift + hold). With hold_full set, load_ready=0, so a hold write and a hold-to-shift move never coincide.
- Reset mid-frame: the current frame is aborted and the holding word is discarded. Outputs take their reset values on the next edge; no partial frame resumes.
- Vacated shift positions fill with 0.
- No bit is ever duplicated or skipped. Each accepted word produces exactly WIDTH valid cycles, in acceptance order.

Test Plan:
- Reset then single word: WIDTH=4, MSB_FIRST=1; load 4'b1011 at edge T.
  - Cycles T+1..T+4: serial_out 1,0,1,1 with serial_valid=1.
  - frame_start only at T+1, frame_end only at T+4.
  - T+5: serial_valid=0, serial_out=0.
- LSB order: MSB_FIRST=0, load 4'b1011 -> serial_out 1,1,0,1 over 4 valid cycles.
- Back-to-back: hold load_valid high with 4'b1011 then 4'b0110.
  - 8 contiguous valid cycles: 1,0,1,1,0,1,1,0.
  - frame_start at cycles 1 and 5; no idle gap.
  - load_ready deasserts while the hold is full.
- Backpressure: present 3 words continuously.
  - The third word waits with load_valid high while load_ready=0.
  - It is accepted only after the hold empties; 12 bits out in order, none lost or duplicated.
- Bypass at last bit: hold empty; assert load_valid with 4'b1100 exactly in the frame_end cycle of 4'b0001.
  - Output 0,0,0,1,1,1,0,0, contiguous.
- Reset mid-frame: load 4'b1111 then 4'b1010; assert reset during bit 2.
  - Next cycle: serial_valid=0, load_ready=0.
  - After release: load_ready=1, no residual bits.
- Loopback: drive serial_out into sipo.serial_in, with MSB_FIRST set to sipo's shift order.
  - sipo.parallel_out equals the loaded word in the cycle after frame_end.
